// File: rtl/ble_cmd_pkg.sv
// ble_cmd_pkg: shared states, command codes, packet layout and checksum helper for the BLE command path
package ble_cmd_pkg;
  typedef enum logic [1:0] {S_SYNC, S_CMD, S_ARG, S_CHK} state_t;
  localparam logic [7:0] CMD_PAN     = 8'h01;
  localparam logic [7:0] CMD_CHARGE  = 8'h02;
  localparam logic [7:0] CMD_NEWGAME = 8'h03;
  localparam logic [1:0] PAN_NONE  = 2'd0;
  localparam logic [1:0] PAN_LEFT  = 2'd1;
  localparam logic [1:0] PAN_RIGHT = 2'd2;
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [7:0] chk;
  } pkt_t;
  function automatic logic [7:0] pkt_sum(input logic [7:0] cmd, input logic [7:0] arg);
    return cmd + arg;
  endfunction
endpackage

// File: rtl/ble_pkt_framer.sv
// ble_pkt_framer: frames SYNC/CMD/ARG/CHK byte packets with inter-byte timeout; BLE_CMD_DEBUG_EN exposes state and packet-done
module ble_pkt_framer
  import ble_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         BYTE_TIMEOUT = 742500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
`ifdef BLE_CMD_DEBUG_EN
  output logic       pkt_done_o,
  output logic [1:0] state_o,
`endif
  output logic       pkt_valid_o,
  output logic       pkt_err_o,
  output logic [7:0] cmd_o,
  output logic [7:0] arg_o
);
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  state_t        state_q, state_d, cur;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    cmd_q, arg_q;
  logic          tmo, done;

  always_ff @(posedge clk_i) state_q <= rst_i ? S_SYNC : state_d;

  // a timeout drops back to S_SYNC first, so a coincident byte is judged as a sync candidate
  always_comb begin
    tmo     = state_q != S_SYNC && timer_q == TW'(BYTE_TIMEOUT);
    cur     = tmo ? S_SYNC : state_q;
    state_d = !byte_valid_i ? cur :
              cur == S_SYNC ? (byte_i == SYNC_BYTE ? S_CMD : S_SYNC) :
              cur == S_CMD  ? S_ARG :
              cur == S_ARG  ? S_CHK : S_SYNC;
    timer_d = (byte_valid_i || cur == S_SYNC) ? '0 : timer_q + 1'b1;
  end

  always_comb begin
    done        = byte_valid_i && cur == S_CHK;
    pkt_valid_o = done && byte_i == pkt_sum(cmd_q, arg_q);
    pkt_err_o   = tmo || (done && byte_i != pkt_sum(cmd_q, arg_q));
    cmd_o       = cmd_q;
    arg_o       = arg_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
      cmd_q   <= '0;
      arg_q   <= '0;
    end else begin
      timer_q <= timer_d;
      if (byte_valid_i && cur == S_CMD) cmd_q <= byte_i;
      if (byte_valid_i && cur == S_ARG) arg_q <= byte_i;
    end
  end

`ifdef BLE_CMD_DEBUG_EN
  assign pkt_done_o = done;
  assign state_o    = state_q;
`endif
endmodule

// File: rtl/ble_cmd_scheduler.sv
// ble_cmd_scheduler: decodes BLE packets into frame-aligned player controls with link failsafe; BLE_CMD_DEBUG_EN builds debug_out capture
module ble_cmd_scheduler
  import ble_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         BYTE_TIMEOUT = 742500,
  parameter int         LINK_TIMEOUT = 37125000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  input  logic        new_frame_in,
  output logic        pan_left_out,
  output logic        pan_right_out,
  output logic        charge_out,
  output logic        new_game_out,
  output logic        link_up_out,
  output logic [7:0]  pkt_count_out,
  output logic [7:0]  err_count_out,
  output logic [31:0] debug_out
);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  logic          pkt_valid, pkt_err, legal, good, err, lost;
  logic [7:0]    cmd, arg;
  logic [1:0]    pan_pend_q, pan_pend_d, pan_q;
  logic          chg_pend_q, chg_pend_d, chg_q;
  logic          ng_pend_q, ng_pend_d, ng_q;
  logic          link_q, link_d;
  logic [LW-1:0] link_tmr_q, link_tmr_d;
  logic [7:0]    pkt_cnt_q, err_cnt_q;
`ifdef BLE_CMD_DEBUG_EN
  logic          pkt_done;
  logic [1:0]    state;
  pkt_t          dbg_q;
`endif

  ble_pkt_framer #(.SYNC_BYTE(SYNC_BYTE), .BYTE_TIMEOUT(BYTE_TIMEOUT)) u_framer (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .byte_i      (byte_in),
    .byte_valid_i(byte_valid_in),
`ifdef BLE_CMD_DEBUG_EN
    .pkt_done_o  (pkt_done),
    .state_o     (state),
`endif
    .pkt_valid_o (pkt_valid),
    .pkt_err_o   (pkt_err),
    .cmd_o       (cmd),
    .arg_o       (arg)
  );

  // link loss releases held pan/charge but keeps a queued new-game request
  always_comb begin
    legal      = cmd == CMD_PAN ? arg < 8'd3 : cmd == CMD_CHARGE ? arg < 8'd2 : cmd == CMD_NEWGAME;
    good       = pkt_valid && legal;
    err        = pkt_err || (pkt_valid && !legal);
    lost       = !good && link_tmr_q == LW'(LINK_TIMEOUT);
    link_tmr_d = good ? '0 : lost ? link_tmr_q : link_tmr_q + 1'b1;
    link_d     = good || (link_q && !lost);
    pan_pend_d = (good && cmd == CMD_PAN) ? arg[1:0] : lost ? PAN_NONE : pan_pend_q;
    chg_pend_d = (good && cmd == CMD_CHARGE) ? arg[0] : !lost && chg_pend_q;
    ng_pend_d  = (good && cmd == CMD_NEWGAME) || (ng_pend_q && !new_frame_in);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pan_pend_q <= PAN_NONE;
      chg_pend_q <= 1'b0;
      ng_pend_q  <= 1'b0;
      pan_q      <= PAN_NONE;
      chg_q      <= 1'b0;
      ng_q       <= 1'b0;
      link_q     <= 1'b0;
      link_tmr_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      pan_pend_q <= pan_pend_d;
      chg_pend_q <= chg_pend_d;
      ng_pend_q  <= ng_pend_d;
      link_q     <= link_d;
      link_tmr_q <= link_tmr_d;
      ng_q       <= new_frame_in && ng_pend_q;
      if (new_frame_in) begin
        pan_q <= pan_pend_q;
        chg_q <= chg_pend_q;
      end
      if (good && pkt_cnt_q != 8'hFF) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign pan_left_out  = pan_q == PAN_LEFT;
  assign pan_right_out = pan_q == PAN_RIGHT;
  assign charge_out    = chg_q;
  assign new_game_out  = ng_q;
  assign link_up_out   = link_q;
  assign pkt_count_out = pkt_cnt_q;
  assign err_count_out = err_cnt_q;

`ifdef BLE_CMD_DEBUG_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) dbg_q <= '0;
    else if (pkt_done) dbg_q <= {cmd, arg, byte_in};
  end
  assign debug_out = {dbg_q, 6'b0, state};
`else
  assign debug_out = 32'h0;
`endif
endmodule

// File: tb/tb_ble_cmd_scheduler.sv
// tb_ble_cmd_scheduler: scoreboard bench for ble_cmd_scheduler with shortened timeouts
module tb_ble_cmd_scheduler;
  logic        clk_in = 1'b0;
  logic        rst_in, byte_valid_in, new_frame_in;
  logic [7:0]  byte_in;
  logic        pan_left_out, pan_right_out, charge_out, new_game_out, link_up_out;
  logic [7:0]  pkt_count_out, err_count_out;
  logic [31:0] debug_out;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic       pl, pr, ch, ng, lk;
    logic [7:0] pc, ec;
  } exp_t;
  exp_t sb[$];

  logic [1:0] m_pan, c_pan;
  logic       m_chg, m_ng, c_chg, ng_now, m_lk;
  logic [7:0] m_pc, m_ec;

  always #5 clk_in = ~clk_in;

  ble_cmd_scheduler #(.SYNC_BYTE(8'hA5), .BYTE_TIMEOUT(40), .LINK_TIMEOUT(2000)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .byte_in      (byte_in),
    .byte_valid_in(byte_valid_in),
    .new_frame_in (new_frame_in),
    .pan_left_out (pan_left_out),
    .pan_right_out(pan_right_out),
    .charge_out   (charge_out),
    .new_game_out (new_game_out),
    .link_up_out  (link_up_out),
    .pkt_count_out(pkt_count_out),
    .err_count_out(err_count_out),
    .debug_out    (debug_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_valid_in = 1'b1;
    tick();
    byte_valid_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic reset_model;
    m_pan = 2'd0; c_pan = 2'd0; m_chg = 1'b0; c_chg = 1'b0;
    m_ng = 1'b0; ng_now = 1'b0; m_lk = 1'b0; m_pc = 8'h0; m_ec = 8'h0;
  endtask

  task automatic model_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    logic [8:0] s;
    logic ok;
    s = {1'b0, c} + {1'b0, a};
    ok = (k == s[7:0]) && ((c == 8'd1 && a <= 8'd2) || (c == 8'd2 && a <= 8'd1) || c == 8'd3);
    if (ok) begin
      if (c == 8'd1) m_pan = a[1:0];
      if (c == 8'd2) m_chg = a[0];
      if (c == 8'd3) m_ng = 1'b1;
      m_lk = 1'b1;
      if (m_pc != 8'hFF) m_pc++;
    end else if (m_ec != 8'hFF) m_ec++;
  endtask

  task automatic model_commit;
    c_pan = m_pan;
    c_chg = m_chg;
    ng_now = m_ng;
    m_ng = 1'b0;
  endtask

  task automatic push_exp;
    exp_t e;
    e.pl = (c_pan == 2'd1);
    e.pr = (c_pan == 2'd2);
    e.ch = c_chg;
    e.ng = ng_now;
    e.lk = m_lk;
    e.pc = m_pc;
    e.ec = m_ec;
    sb.push_back(e);
  endtask

  task automatic compare_out;
    exp_t e;
    e = sb.pop_front();
    check("pan_left", pan_left_out, e.pl);
    check("pan_right", pan_right_out, e.pr);
    check("charge", charge_out, e.ch);
    check("new_game", new_game_out, e.ng);
    check("link_up", link_up_out, e.lk);
    check("pkt_count", pkt_count_out, e.pc);
    check("err_count", err_count_out, e.ec);
  endtask

  task automatic frame;
    model_commit();
    push_exp();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    compare_out();
    ng_now = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k, input bit frm);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    if (frm) model_commit();
    byte_in = k;
    byte_valid_in = 1'b1;
    new_frame_in = frm;
    tick();
    byte_valid_in = 1'b0;
    new_frame_in = 1'b0;
    model_pkt(c, a, k);
    if (frm) begin
      push_exp();
      compare_out();
      ng_now = 1'b0;
    end
    tick();
    tick();
  endtask

  initial begin
    rst_in = 1'b1; byte_valid_in = 1'b0; new_frame_in = 1'b0; byte_in = 8'h0;
    reset_model();
    repeat (3) tick();
    rst_in = 1'b0;
    push_exp();
    compare_out();
    send_pkt(8'h01, 8'h01, 8'h02, 1'b0);
    frame();
    send_pkt(8'h02, 8'h01, 8'h04, 1'b0);
    frame();
    send_pkt(8'h02, 8'h01, 8'h03, 1'b0);
    frame();
    send_pkt(8'h03, 8'h00, 8'h03, 1'b0);
    frame();
    tick();
    check("ng_width", new_game_out, 1'b0);
    frame();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (50) tick();
    if (m_ec != 8'hFF) m_ec++;
    send_pkt(8'h01, 8'h02, 8'h03, 1'b0);
    frame();
    send_pkt(8'h01, 8'h01, 8'h02, 1'b1);
    frame();
    send_pkt(8'h01, 8'h03, 8'h04, 1'b0);
    send_pkt(8'h07, 8'h00, 8'h07, 1'b0);
    frame();
    send_pkt(8'h03, 8'h05, 8'h08, 1'b0);
    repeat (2100) tick();
    m_lk = 1'b0; m_pan = 2'd0; m_chg = 1'b0;
    push_exp();
    compare_out();
    frame();
    for (int i = 0; i < 256; i++) send_pkt(8'h02, 8'h01, 8'h04, 1'b0);
    frame();
    send_byte(8'hA5);
    send_byte(8'h01);
    rst_in = 1'b1;
    tick();
    reset_model();
    push_exp();
    compare_out();
    rst_in = 1'b0;
    send_pkt(8'h02, 8'h01, 8'h03, 1'b0);
    frame();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
